// File: rtl/gomoku_pkg.sv
// Shared types and board-size defaults for the Gomoku front-panel logic.
package gomoku_pkg;

  localparam int BOARD_N = 15;
  localparam int COORD_W = 4;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic {
    IDLE,
    REQ
  } cursor_state_t;

endpackage

// File: rtl/coord_step.sv
// One-axis cursor stepper: cancels opposing pulses and wraps or saturates at the board edge.
// Edge behaviour: `CURSOR_WRAP_EN defined -> wrap, undefined -> saturate.
module coord_step
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = gomoku_pkg::BOARD_N,
  parameter int COORD_W = gomoku_pkg::COORD_W
) (
  input  logic [COORD_W-1:0] coord,
  input  logic               inc,
  input  logic               dec,
  input  logic               hold,
  output logic [COORD_W-1:0] next_coord,
  output logic               changed
);

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [COORD_W:0] MAX = (COORD_W+1)'(BOARD_N - 1);

  logic [COORD_W:0] wide;
  logic [COORD_W:0] stepped;

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    wide    = {1'b0, coord};
    stepped = wide;
    // inc ^ dec: both pulses together cancel, leaving the axis untouched
    if (!hold && (inc ^ dec)) begin
      if (inc) begin
        if (wide >= MAX) stepped = WRAP ? '0 : MAX;
        else             stepped = wide + 1'b1;
      end else begin
        if (wide == '0)  stepped = WRAP ? MAX : '0;
        else             stepped = wide - 1'b1;
      end
    end
    next_coord = stepped[COORD_W-1:0];
    changed    = (stepped != wide);
  end

endmodule

// File: rtl/cursor_controller.sv
// Gomoku cursor controller: moves the cursor from button pulses and issues placement requests
// over valid/ready. Edge wrapping is enabled by defining `CURSOR_WRAP_EN (see coord_step).
module cursor_controller
  import gomoku_pkg::*;
#(
  parameter int BOARD_N = gomoku_pkg::BOARD_N,
  parameter int COORD_W = gomoku_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_center,
  input  logic               enable,
  output logic [COORD_W-1:0] cur_x,
  output logic [COORD_W-1:0] cur_y,
  output logic               cursor_moved,
  output logic               place_valid,
  output logic [COORD_W-1:0] place_x,
  output logic [COORD_W-1:0] place_y,
  input  logic               place_ready
);

  localparam logic [COORD_W-1:0] START = COORD_W'(BOARD_N / 2);

  cursor_state_t      state;
  logic               hold;
  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               changed_x;
  logic               changed_y;

  // A pending request, or one being raised this cycle, swallows all direction pulses.
  assign hold = (state == REQ) || (btn_center && enable);

  coord_step #(.BOARD_N(BOARD_N), .COORD_W(COORD_W)) u_step_x (
    .coord      (cur_x),
    .inc        (btn_right),
    .dec        (btn_left),
    .hold       (hold),
    .next_coord (next_x),
    .changed    (changed_x)
  );

  coord_step #(.BOARD_N(BOARD_N), .COORD_W(COORD_W)) u_step_y (
    .coord      (cur_y),
    .inc        (btn_down),
    .dec        (btn_up),
    .hold       (hold),
    .next_coord (next_y),
    .changed    (changed_y)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cur_x        <= START;
      cur_y        <= START;
      cursor_moved <= 1'b0;
      place_valid  <= 1'b0;
      place_x      <= '0;
      place_y      <= '0;
    end else begin
      case (state)
        IDLE: begin
          cur_x        <= next_x;
          cur_y        <= next_y;
          cursor_moved <= changed_x || changed_y;
          if (btn_center && enable) begin
            // Latch the pre-move cursor; same-cycle moves are already held off.
            place_x     <= cur_x;
            place_y     <= cur_y;
            place_valid <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          cursor_moved <= 1'b0;
          if (place_ready) begin
            place_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          place_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_controller.sv
// Directed self-checking bench for cursor_controller; follows `CURSOR_WRAP_EN for edge expectations.
module tb_cursor_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_up, btn_down, btn_left, btn_right, btn_center;
  logic       enable;
  logic [3:0] cur_x, cur_y;
  logic       cursor_moved;
  logic       place_valid;
  logic [3:0] place_x, place_y;
  logic       place_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cursor_controller dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_center   (btn_center),
    .enable       (enable),
    .cur_x        (cur_x),
    .cur_y        (cur_y),
    .cursor_moved (cursor_moved),
    .place_valid  (place_valid),
    .place_x      (place_x),
    .place_y      (place_y),
    .place_ready  (place_ready)
  );

  // Drive one cycle of button pulses, then sample just after the rising edge.
  task automatic step(input logic u, input logic d, input logic l, input logic r, input logic c);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r; btn_center = c;
    @(posedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_center = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({cur_x, cur_y, cursor_moved} !== {4'd7, 4'd7, 1'b0}) begin
      bad++;
      $display("FAIL reset_cursor: got x=%0d y=%0d moved=%b, want x=7 y=7 moved=0", cur_x, cur_y, cursor_moved);
    end
    total++;
    if ({place_valid, place_x, place_y} !== {1'b0, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL reset_place: got valid=%b x=%0d y=%0d, want valid=0 x=0 y=0", place_valid, place_x, place_y);
    end
  endtask

  task automatic test_move_right();
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 0);
      total++;
      if ({cur_x, cur_y, cursor_moved} !== {4'(7 + i), 4'd7, 1'b1}) begin
        bad++;
        $display("FAIL move_right_%0d: got x=%0d y=%0d moved=%b, want x=%0d y=7 moved=1", i, cur_x, cur_y, cursor_moved, 7 + i);
      end
    end
    step(0, 0, 0, 0, 0);
    total++;
    if ({cur_x, cursor_moved} !== {4'd10, 1'b0}) begin
      bad++;
      $display("FAIL move_idle: got x=%0d moved=%b, want x=10 moved=0", cur_x, cursor_moved);
    end
  endtask

  task automatic test_top_edge();
    logic [3:0] exp_y;
    logic       exp_moved;
    for (int i = 1; i <= 7; i++) step(1, 0, 0, 0, 0);
    total++;
    if ({cur_x, cur_y, cursor_moved} !== {4'd10, 4'd0, 1'b1}) begin
      bad++;
      $display("FAIL up_to_edge: got x=%0d y=%0d moved=%b, want x=10 y=0 moved=1", cur_x, cur_y, cursor_moved);
    end
`ifdef CURSOR_WRAP_EN
    exp_y = 4'd14; exp_moved = 1'b1;
`else
    exp_y = 4'd0;  exp_moved = 1'b0;
`endif
    step(1, 0, 0, 0, 0);
    total++;
    if ({cur_y, cursor_moved} !== {exp_y, exp_moved}) begin
      bad++;
      $display("FAIL up_past_edge: got y=%0d moved=%b, want y=%0d moved=%b", cur_y, cursor_moved, exp_y, exp_moved);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    step(1, 1, 0, 1, 0);
    total++;
    if ({cur_x, cur_y, cursor_moved} !== {4'd8, 4'd7, 1'b1}) begin
      bad++;
      $display("FAIL cancel_y: got x=%0d y=%0d moved=%b, want x=8 y=7 moved=1", cur_x, cur_y, cursor_moved);
    end
    step(0, 0, 1, 1, 0);
    total++;
    if ({cur_x, cur_y, cursor_moved} !== {4'd8, 4'd7, 1'b0}) begin
      bad++;
      $display("FAIL cancel_x: got x=%0d y=%0d moved=%b, want x=8 y=7 moved=0", cur_x, cur_y, cursor_moved);
    end
  endtask

  task automatic test_placement_wait();
    enable = 1'b1;
    place_ready = 1'b0;
    step(0, 0, 1, 0, 1);
    total++;
    if ({place_valid, place_x, place_y, cur_x} !== {1'b1, 4'd8, 4'd7, 4'd8}) begin
      bad++;
      $display("FAIL place_raise: got valid=%b px=%0d py=%0d cx=%0d, want valid=1 px=8 py=7 cx=8", place_valid, place_x, place_y, cur_x);
    end
    for (int i = 0; i < 5; i++) begin
      enable = (i % 2 == 0);
      step(0, 0, 1, 0, i == 2);
      total++;
      if ({place_valid, place_x, place_y, cur_x, cursor_moved} !== {1'b1, 4'd8, 4'd7, 4'd8, 1'b0}) begin
        bad++;
        $display("FAIL place_hold_%0d: got valid=%b px=%0d py=%0d cx=%0d moved=%b, want valid=1 px=8 py=7 cx=8 moved=0",
                 i, place_valid, place_x, place_y, cur_x, cursor_moved);
      end
    end
    enable = 1'b1;
    place_ready = 1'b1;
    step(0, 0, 0, 0, 0);
    place_ready = 1'b0;
    total++;
    if (place_valid !== 1'b0) begin
      bad++;
      $display("FAIL place_accept: got valid=%b, want valid=0", place_valid);
    end
    step(0, 0, 1, 0, 0);
    total++;
    if ({cur_x, cursor_moved, place_valid} !== {4'd7, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL after_accept_move: got x=%0d moved=%b valid=%b, want x=7 moved=1 valid=0", cur_x, cursor_moved, place_valid);
    end
  endtask

  task automatic test_zero_wait();
    enable = 1'b1;
    place_ready = 1'b1;
    step(0, 0, 0, 0, 1);
    total++;
    if ({place_valid, place_x, place_y} !== {1'b1, 4'd7, 4'd7}) begin
      bad++;
      $display("FAIL zero_wait_raise: got valid=%b px=%0d py=%0d, want valid=1 px=7 py=7", place_valid, place_x, place_y);
    end
    step(0, 0, 0, 0, 0);
    total++;
    if (place_valid !== 1'b0) begin
      bad++;
      $display("FAIL zero_wait_done: got valid=%b, want valid=0", place_valid);
    end
    place_ready = 1'b0;
  endtask

  task automatic test_disabled_center();
    enable = 1'b0;
    step(0, 1, 0, 0, 1);
    total++;
    if ({place_valid, cur_x, cur_y, cursor_moved} !== {1'b0, 4'd7, 4'd8, 1'b1}) begin
      bad++;
      $display("FAIL disabled_center: got valid=%b x=%0d y=%0d moved=%b, want valid=0 x=7 y=8 moved=1",
               place_valid, cur_x, cur_y, cursor_moved);
    end
  endtask

  task automatic test_reset_mid_request();
    enable = 1'b1;
    place_ready = 1'b0;
    step(0, 0, 0, 0, 1);
    total++;
    if ({place_valid, place_x, place_y} !== {1'b1, 4'd7, 4'd8}) begin
      bad++;
      $display("FAIL mid_req_raise: got valid=%b px=%0d py=%0d, want valid=1 px=7 py=8", place_valid, place_x, place_y);
    end
    do_reset();
    total++;
    if ({place_valid, place_x, place_y, cur_x, cur_y} !== {1'b0, 4'd0, 4'd0, 4'd7, 4'd7}) begin
      bad++;
      $display("FAIL mid_req_reset: got valid=%b px=%0d py=%0d x=%0d y=%0d, want valid=0 px=0 py=0 x=7 y=7",
               place_valid, place_x, place_y, cur_x, cur_y);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_center = 0;
    enable = 1'b0;
    place_ready = 1'b0;
    test_reset();
    test_move_right();
    test_top_edge();
    test_cancel();
    test_placement_wait();
    test_zero_wait();
    test_disabled_center();
    test_reset_mid_request();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
